// File: rtl/bi_link_pkg.sv
// -----------------------------------------------------------------------------
// bi_link_pkg
// Shared definitions for the bus-invert link stream:
//   - state_t        : run controller states (IDLE/RUN/DRAIN/DONE)
//   - part_width()   : width of partition g when K bits are split into G parts
//                      (the first K%G partitions carry one extra bit)
//   - part_offset()  : bit offset of partition g, packed from bit 0 upward
//   - popcount()     : number of set bits in a vector of up to POP_MAX_W bits
// -----------------------------------------------------------------------------
package bi_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Widest vector popcount() accepts; callers zero-extend into it.
    localparam int POP_MAX_W = 256;

    function automatic int part_width(input int k, input int gn, input int g);
        return (g < (k % gn)) ? (k / gn + 1) : (k / gn);
    endfunction

    function automatic int part_offset(input int k, input int gn, input int g);
        int off;
        off = 0;
        for (int i = 0; i < g; i++) begin
            off += part_width(k, gn, i);
        end
        return off;
    endfunction

    function automatic int popcount(input logic [POP_MAX_W-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/bi_part_encoder.sv
// -----------------------------------------------------------------------------
// bi_part_encoder
// Bus-invert encoder for one W-bit partition. Holds the previously sent data
// bits (xprev) and invert bit (invprev) of this partition.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear history to 0 (run start)
//   load       : accepted input word; history takes the current x/inv
//   mode       : 0 = pass-through (inv forced 0), 1 = bus-invert
//   s          : source bits of this partition
//   x, inv     : encoded data bits and invert bit (combinational)
// -----------------------------------------------------------------------------
module bi_part_encoder
    import bi_link_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         mode,
    input  logic [W-1:0] s,
    output logic [W-1:0] x,
    output logic         inv
);

    logic [W-1:0] xprev;
    logic         invprev;
    int           d;

    // Distance is measured on data bits only. An exact tie (d == W/2) keeps
    // the previous invert state so the invert line itself does not toggle.
    always_comb begin
        d   = popcount(POP_MAX_W'(s ^ xprev));
        inv = mode & ((d > W / 2) | ((d == W / 2) & invprev));
        x   = inv ? ~s : s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xprev   <= '0;
            invprev <= 1'b0;
        end else if (clr) begin
            xprev   <= '0;
            invprev <= 1'b0;
        end else if (load) begin
            xprev   <= x;
            invprev <= inv;
        end
    end

endmodule

// File: rtl/bi_link_stream.sv
// -----------------------------------------------------------------------------
// bi_link_stream
// Stream-handshaked bus-invert link: encodes K-bit words into G partitions with
// one invert bit each, registers the (K+G)-bit bus word {X, INV}, decodes it
// back and compares it against a reference copy of the source word.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, num_words, mode: run start (IDLE only), word count and mode sampled
//   inj_en, inj_mask      : XOR fault mask applied to the bus word being loaded
//   in_valid/in_ready/in_data    : input stream
//   out_valid/out_ready/out_data : decoded output stream
//   busy, done            : controller not idle / one-cycle run-end pulse
//   trans_total           : saturating count of bus bit toggles this run
//   words_out             : words delivered this run
//   mismatch_cnt          : saturating count of decoded != reference
// -----------------------------------------------------------------------------
module bi_link_stream
    import bi_link_pkg::*;
#(
    parameter int K     = 32,
    parameter int G     = 5,
    parameter int CNT_W = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      num_words,
    input  logic             mode,
    input  logic             inj_en,
    input  logic [K+G-1:0]   inj_mask,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     out_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] trans_total,
    output logic [15:0]      words_out,
    output logic [15:0]      mismatch_cnt
);

    localparam int BW = K + G;

    function automatic logic [CNT_W-1:0] sat_add_trans(input logic [CNT_W-1:0] acc,
                                                       input logic [BW-1:0]    diff);
        logic [CNT_W:0] sum;
        sum = {1'b0, acc} + (CNT_W + 1)'(popcount(POP_MAX_W'(diff)));
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t         state, state_nx;
    logic [15:0]    num_words_r;
    logic           mode_r;
    logic [15:0]    accepted;
    logic           start_ok, adv, fire_in, fire_out;

    logic [K-1:0]   x_enc;
    logic [G-1:0]   inv_enc;
    logic [BW-1:0]  bus_new;
    logic [BW-1:0]  bus_p1;
    logic           vld_p1;
    logic [K-1:0]   dec_p1;
    logic [K-1:0]   data_p2;
    logic           vld_p2;

    logic [K-1:0]   fifo_q [2];
    logic [1:0]     fifo_cnt;

    assign start_ok  = (state == IDLE) & start;
    assign adv       = ~vld_p2 | out_ready;
    assign fire_in   = in_valid & in_ready;
    assign fire_out  = vld_p2 & out_ready;
    assign out_valid = vld_p2;
    assign out_data  = data_p2;

    // Per-partition encoders and the matching decode slice of the bus register
    for (genvar g = 0; g < G; g++) begin : g_part
        localparam int W   = part_width(K, G, g);
        localparam int OFF = part_offset(K, G, g);

        bi_part_encoder #(.W(W)) u_enc (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start_ok),
            .load  (fire_in),
            .mode  (mode_r),
            .s     (in_data[OFF +: W]),
            .x     (x_enc[OFF +: W]),
            .inv   (inv_enc[g])
        );

        assign dec_p1[OFF +: W] = bus_p1[G + OFF +: W] ^ {W{bus_p1[g]}};
    end

    // History keeps the clean word; only the registered bus sees the fault.
    assign bus_new = {x_enc, inv_enc} ^ (inj_en ? inj_mask : '0);

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = 1'b0;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                in_ready = (accepted < num_words_r) & adv;
                if (accepted == num_words_r) state_nx = DRAIN;
            end
            DRAIN: begin
                // Both stages are empty after this edge: stage 1 holds nothing
                // and stage 2 is empty or handing off its last word now.
                if (!vld_p1 && (!vld_p2 || out_ready)) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            num_words_r  <= '0;
            mode_r       <= 1'b0;
            accepted     <= '0;
            words_out    <= '0;
            mismatch_cnt <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                num_words_r  <= num_words;
                mode_r       <= mode;
                accepted     <= '0;
                words_out    <= '0;
                mismatch_cnt <= '0;
            end else begin
                if (fire_in) accepted <= accepted + 16'd1;
                if (fire_out) begin
                    words_out <= words_out + 16'd1;
                    if (fifo_q[0] != data_p2) mismatch_cnt <= sat_inc16(mismatch_cnt);
                end
            end
        end
    end

    // Stage 1: bus register (also the previous bus word for toggle counting)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_p1      <= '0;
            vld_p1      <= 1'b0;
            trans_total <= '0;
        end else if (start_ok) begin
            bus_p1      <= '0;
            vld_p1      <= 1'b0;
            trans_total <= '0;
        end else if (adv) begin
            vld_p1 <= fire_in;
            if (fire_in) begin
                bus_p1      <= bus_new;
                trans_total <= sat_add_trans(trans_total, bus_new ^ bus_p1);
            end
        end
    end

    // Stage 2: decoded output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p2 <= '0;
            vld_p2  <= 1'b0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) data_p2 <= dec_p1;
        end
    end

    // Reference FIFO: at most two words are in flight, so it never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt  <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            case ({fire_in, fire_out})
                2'b10: begin
                    fifo_q[fifo_cnt[0]] <= in_data;
                    fifo_cnt            <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo_q[0] <= fifo_q[1];
                    fifo_cnt  <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        fifo_q[0] <= in_data;
                    end else begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bi_link_stream.sv
module tb_bi_link_stream;

    localparam int K     = 32;
    localparam int G     = 5;
    localparam int CNT_W = 22;
    localparam int BW    = K + G;
    localparam longint TRANS_MAX = (64'sd1 <<< CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [15:0]       num_words;
    logic              mode;
    logic              inj_en;
    logic [BW-1:0]     inj_mask;
    logic              in_valid;
    logic              in_ready;
    logic [K-1:0]      in_data;
    logic              out_valid;
    logic              out_ready;
    logic [K-1:0]      out_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  trans_total;
    logic [15:0]       words_out;
    logic [15:0]       mismatch_cnt;

    bi_link_stream #(.K(K), .G(G), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_words    (num_words),
        .mode         (mode),
        .inj_en       (inj_en),
        .inj_mask     (inj_mask),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done),
        .trans_total  (trans_total),
        .words_out    (words_out),
        .mismatch_cnt (mismatch_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int            pw [G];
    int            po [G];
    logic [K-1:0]  pmask [G];

    logic [K-1:0]  words   [64];
    logic [K-1:0]  exp_out [64];
    bit            inj_on  [64];
    logic [BW-1:0] inj_msk [64];
    longint        exp_trans;
    int            exp_mism;

    longint        last_trans;
    int            last_words;
    int            last_mism;
    logic [K-1:0]  first_out;
    bit            stall_seen;
    bit            stall_bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inj();
        for (int i = 0; i < 64; i++) begin
            inj_on[i]  = 1'b0;
            inj_msk[i] = '0;
        end
    endtask

    // Reference: encode each word in acceptance order from the partition rules,
    // apply the fault mask, count bus toggles, decode, compare with the source.
    task automatic model(input int n, input bit md);
        logic [K-1:0]  xprev, s, x, dec;
        logic [G-1:0]  invprev, inv;
        logic [BW-1:0] prev, bus;
        longint        tr;
        int            d;
        xprev = '0; invprev = '0; prev = '0; tr = 0; exp_mism = 0;
        for (int i = 0; i < n; i++) begin
            s = words[i]; x = s; inv = '0;
            if (md) begin
                for (int g = 0; g < G; g++) begin
                    d = $countones((s ^ xprev) & pmask[g]);
                    if ((d > pw[g] / 2) || ((d == pw[g] / 2) && invprev[g])) begin
                        inv[g] = 1'b1;
                        x      = x ^ pmask[g];
                    end
                end
            end
            xprev = x; invprev = inv;
            bus = {x, inv};
            if (inj_on[i]) bus = bus ^ inj_msk[i];
            tr += $countones(bus ^ prev);
            prev = bus;
            dec = bus[BW-1:G];
            for (int g = 0; g < G; g++) begin
                if (bus[g]) dec = dec ^ pmask[g];
            end
            exp_out[i] = dec;
            if (dec != s) exp_mism++;
        end
        exp_trans = (tr > TRANS_MAX) ? TRANS_MAX : tr;
    endtask

    // One run: rdy_kind 0 = ready except a stall window, 1 = random ready.
    // noise adds input-valid gaps, mid-run mode toggles and ignored start pulses.
    task automatic do_run(input int n, input bit md, input int rdy_kind, input int st_at,
                          input int st_len, input bit noise, input string tag);
        int           sent, recv, cyc, last_out, done_at, budget;
        bit           was_stalled;
        logic [K-1:0] prev_od;
        model(n, md);
        start = 1'b1; num_words = 16'(n); mode = md;
        @(posedge clk); #1;
        start = 1'b0;
        sent = 0; recv = 0; cyc = 0; last_out = -1; done_at = -1;
        budget = 30 * n + 40;
        was_stalled = 1'b0; prev_od = '0;
        stall_seen = 1'b0; stall_bad = 1'b0; first_out = '0;
        while (cyc < budget && done_at < 0) begin
            in_valid = (sent < n) && (!noise || $urandom_range(3) != 0);
            in_data  = (sent < n) ? words[sent] : K'($urandom);
            inj_en   = (sent < n) && inj_on[sent];
            inj_mask = (sent < n) ? inj_msk[sent] : '0;
            if (rdy_kind == 0) out_ready = !(cyc >= st_at && cyc < st_at + st_len);
            else               out_ready = ($urandom_range(2) != 0);
            if (noise) begin
                mode = 1'($urandom);
                start = ($urandom_range(7) == 0);
                num_words = 16'($urandom);
            end
            #1;
            if (was_stalled && (!out_valid || out_data !== prev_od)) stall_bad = 1'b1;
            if (out_valid && !out_ready) begin
                stall_seen = 1'b1;
                if (in_ready) stall_bad = 1'b1;
                was_stalled = 1'b1;
                prev_od = out_data;
            end else begin
                was_stalled = 1'b0;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (recv < n) begin
                    check($sformatf("%s_data%0d", tag, recv), 64'(out_data), 64'(exp_out[recv]));
                    if (recv == 0) first_out = out_data;
                end else begin
                    check($sformatf("%s_extra_word", tag), 64'(recv), 64'(n - 1));
                end
                recv++;
                last_out = cyc;
            end
            if (done) done_at = cyc;
            if (done_at < 0) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0; in_valid = 1'b0; inj_en = 1'b0; out_ready = 1'b1;
        check({tag, "_done_seen"}, 64'(done_at >= 0), 64'd1);
        if (done_at >= 0) begin
            last_trans = longint'(trans_total);
            last_words = int'(words_out);
            last_mism  = int'(mismatch_cnt);
            check({tag, "_trans"}, 64'(trans_total), 64'(exp_trans));
            check({tag, "_words_out"}, 64'(words_out), 64'(n));
            check({tag, "_mismatch"}, 64'(mismatch_cnt), 64'(exp_mism));
            check({tag, "_recv"}, 64'(recv), 64'(n));
            if (n > 0) check({tag, "_done_timing"}, 64'(done_at), 64'(last_out + 1));
            check({tag, "_stall_rules"}, 64'(stall_bad), 64'd0);
        end
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        po[0] = 0;
        for (int g = 0; g < G; g++) begin
            pw[g] = K / G + ((g < K % G) ? 1 : 0);
            if (g > 0) po[g] = po[g-1] + pw[g-1];
            pmask[g] = '0;
            for (int b = 0; b < pw[g]; b++) pmask[g][po[g] + b] = 1'b1;
        end
        clear_inj();

        rst_n = 1'b0; start = 1'b0; num_words = '0; mode = 1'b0;
        inj_en = 1'b0; inj_mask = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_counters", 64'({trans_total, words_out, mismatch_cnt}), 64'd0);

        // 0 then all-ones, bus-invert: every partition inverts on word 2
        words[0] = 32'h0000_0000; words[1] = 32'hFFFF_FFFF;
        do_run(2, 1'b1, 0, 1000, 0, 1'b0, "bi_basic");
        check("bi_basic_trans_const", 64'(last_trans), 64'd5);
        check("bi_basic_first", 64'(first_out), 64'h0);

        do_run(2, 1'b0, 0, 1000, 0, 1'b0, "bypass");
        check("bypass_trans_const", 64'(last_trans), 64'd32);

        // Partition 2 (bits 19:14) tie with INVprev = 0 keeps INV_2 = 0
        words[0] = 32'h0000_0000; words[1] = 32'h0001_C000;
        do_run(2, 1'b1, 0, 1000, 0, 1'b0, "tie_prev0");
        check("tie_prev0_trans_const", 64'(last_trans), 64'd3);

        // Same tie with INVprev = 1 keeps INV_2 = 1
        words[0] = 32'h000F_C000; words[1] = 32'h0001_C000;
        do_run(2, 1'b1, 0, 1000, 0, 1'b0, "tie_prev1");
        check("tie_prev1_trans_const", 64'(last_trans), 64'd4);

        // Fault on INV_0 of a zero word
        words[0] = 32'h0; inj_on[0] = 1'b1; inj_msk[0] = BW'(1);
        do_run(1, 1'b1, 0, 1000, 0, 1'b0, "inject");
        check("inject_out_const", 64'(first_out), 64'h7F);
        check("inject_mism_const", 64'(last_mism), 64'd1);
        check("inject_trans_const", 64'(last_trans), 64'd1);
        clear_inj();

        // 5-cycle output stall in a 10-word run
        for (int i = 0; i < 10; i++) words[i] = K'($urandom);
        do_run(10, 1'b1, 0, 4, 5, 1'b0, "stall");
        check("stall_seen", 64'(stall_seen), 64'd1);
        check("stall_words_const", 64'(last_words), 64'd10);
        check("stall_mism_const", 64'(last_mism), 64'd0);

        // Reset in the middle of a run
        start = 1'b1; num_words = 16'd10; mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_data = K'($urandom);
            @(posedge clk); #1;
        end
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_counters", 64'({trans_total, words_out, mismatch_cnt}), 64'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_run(0, 1'b1, 0, 1000, 0, 1'b0, "zero");
        check("zero_trans_const", 64'(last_trans), 64'd0);
        check("zero_words_const", 64'(last_words), 64'd0);

        // Randomised runs with gaps, random ready, faults and ignored controls
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(24, 1);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(3))
                    0:       words[i] = 32'h0;
                    1:       words[i] = 32'hFFFF_FFFF;
                    default: words[i] = K'($urandom);
                endcase
                inj_on[i]  = ($urandom_range(5) == 0);
                inj_msk[i] = BW'(1) << $urandom_range(BW - 1);
            end
            do_run(n, 1'($urandom), 1, 0, 0, 1'b1, $sformatf("rand%0d", r));
            clear_inj();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bi_link_stream.md
# bi_link_stream

Parametrised, stream-handshaked successor of the bus-invert encode/bus/decode data path. It accepts K-bit words over valid/ready and splits each word into G partitions, each with its own invert bit. Each word is encoded onto a (K+G)-bit bus register, decoded back, and self-checked against a reference copy. Per run, under a start/done controller, it accumulates bus transition count, word count and mismatch count, and supports bypass mode and bus-fault injection.

## Interface
- K, 32, payload width (K ≥ 2G)
- G, 5, partition count; first K%G partitions are K/G+1 bits wide, remaining K/G bits, packed from bit 0 upward
- CNT_W, 22, width of transition accumulator
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  run start pulse; honoured only in IDLE
- num_words  in  16  words to accept this run; sampled on start
- mode  in  1  0 = bypass (INV forced 0), 1 = bus-invert; sampled on start
- inj_en  in  1  apply inj_mask to the bus word being registered
- inj_mask  in  K+G  XOR fault mask on bus word {X, INV}
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_data  in  K  source word
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_data  out  K  decoded word
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at run end
- trans_total  out  CNT_W  saturating sum of bus bit toggles
- words_out  out  16  words delivered this run
- mismatch_cnt  out  16  saturating count of decoded ≠ reference

## Operation
- FSM: IDLE → RUN on start. RUN → DRAIN when accepted == num_words. DRAIN → DONE when both pipeline stages are empty. DONE → IDLE after one cycle, with done = 1.
- num_words = 0: IDLE → RUN → DRAIN → DONE with no transfers.
- On start: clear trans_total, words_out and mismatch_cnt. Clear the encoder history (Xprev, INVprev per partition) and the previous bus word to 0.
- Encode, partition g of width w:
  - d = popcount(S_g ^ Xprev_g), computed over data bits only.
  - INV_g = (d > w/2) | (d == w/2 & INVprev_g), using integer w/2.
  - X_g = INV_g ? ~S_g : S_g.
  - History updates only on accepted input handshake.
  - mode 0: INV = 0, X = S.
- Bus word is {X, INV}, with INV in the LSBs, XOR inj_mask when inj_en. The encoder history stores the un-injected X/INV.
- On every bus-register load: trans_total += popcount(bus_new ^ bus_prev), saturating; bus_prev ← bus_new.
- Decode: S_out_g = INV_g ? ~X_g : X_g, taken from the bus register, registered into out_data.
- Reference FIFO (depth 2) pushes in_data on input handshake and pops on output handshake. If popped ≠ out_data, increment mismatch_cnt, saturating at 0xFFFF.
- words_out increments on each output handshake.
- start outside IDLE is ignored. Mode changes mid-run are ignored.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, busy 0, done 0, all counters 0; FSM in IDLE; FIFO empty.
- Latency: input handshake at cycle t → bus register at t+1 → out_valid/out_data at t+2. Throughput is 1 word/cycle.
- Global advance: adv = ~out_valid | out_ready.
- in_ready = (state == RUN) & (accepted < num_words) & adv.
- During a stall, out_data, the bus register, trans_total and the encoder history hold. No word is lost or duplicated.
- out_valid stays high until out_ready; out_data is stable while stalled.
- Counters are final and valid in the done cycle, and hold until the next start.
- rst_n mid-run aborts the run immediately to reset values. No done is issued.

## Structure
- Shared package bi_link_pkg holds:
  - functions part_width(g) and part_offset(g), from K and G;
  - a popcount function;
  - FSM state enum IDLE/RUN/DRAIN/DONE.
- Sub-module bi_part_encoder, one per partition, generated G times. It holds the Xprev/INVprev registers, a clear input, the popcount, the tie rule and the invert logic.

## Test plan
Defaults K=32, G=5, partition widths 7,7,6,6,6.
- mode 1, num_words 2, data 0x00000000 then 0xFFFFFFFF → second bus word X=0, INV=5'b11111; out_data 0x00000000, 0xFFFFFFFF; trans_total 5; mismatch_cnt 0; done one cycle after last output.
- Same stream with mode 0 → trans_total 32; out_data identical.
- mode 1, partition 2 (bits 19:14) toggles exactly 3 bits with INVprev=0 → INV_2=0. Same with INVprev=1 → INV_2=1.
- inj_en with inj_mask=1 (INV_0) on word 0x0 → out_data 0x0000007F; mismatch_cnt 1; trans_total counts the injected toggle.
- out_ready low 5 cycles mid-run of 10 words → in_ready low within the stall; all 10 words are delivered in order; words_out 10; mismatch 0.
- rst_n asserted during RUN → all outputs return to reset values next edge. A following start with num_words 0 gives done with all counters 0.
